// File: rtl/xfer_sequencer.sv
// Transfer sequencer: sequences a host command, its optional data phase,
// the automatic CMD12 that ends a multi-block transfer, and completion or error reporting.
module xfer_sequencer #(
  parameter int DAT_TIMEOUT = 4096
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start_flag,
  input  logic [5:0]  cmd_index,
  input  logic        data_present,
  input  logic        multiple_blk,
  input  logic [15:0] block_count,
  input  logic        cmd_complete,
  input  logic        cmd_timeout,
  input  logic        block_done,
  input  logic        STOP,
  input  logic        err_clr,
  output logic        new_cmd,
  output logic [5:0]  cmd_index_out,
  output logic        dat_start,
  output logic        cmd_inhibit,
  output logic        dat_inhibit,
  output logic        xfer_complete,
  output logic        error_flag,
  output logic [15:0] blocks_left
);

  localparam int WDW = $clog2(DAT_TIMEOUT) + 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(DAT_TIMEOUT - 1);
  localparam logic [5:0] STOP_CMD_IDX = 6'd12;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_RESP  = 3'd2,
    DATA       = 3'd3,
    STOP_ISSUE = 3'd4,
    STOP_WAIT  = 3'd5,
    DONE       = 3'd6,
    ERROR      = 3'd7
  } state_t;

  state_t         r_state;
  logic [5:0]     r_cmd_idx;
  logic           r_data_present;
  logic           r_multiple_blk;
  logic [WDW-1:0] r_wdog;

  // A multi-block data command with a zero block count cannot be run at all.
  logic w_bad_count;
  assign w_bad_count = data_present & multiple_blk & (block_count == 16'd0);

  // Single state machine; every output is set on the transition into the
  // state in which it must be visible, so outputs stay registered.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state        <= IDLE;
      r_cmd_idx      <= 6'd0;
      r_data_present <= 1'b0;
      r_multiple_blk <= 1'b0;
      r_wdog         <= '0;
      new_cmd        <= 1'b0;
      cmd_index_out  <= 6'd0;
      dat_start      <= 1'b0;
      cmd_inhibit    <= 1'b0;
      dat_inhibit    <= 1'b0;
      xfer_complete  <= 1'b0;
      error_flag     <= 1'b0;
      blocks_left    <= 16'd0;
    end else begin
      // Pulse outputs default low so none can stay high two cycles running.
      new_cmd       <= 1'b0;
      dat_start     <= 1'b0;
      xfer_complete <= 1'b0;

      case (r_state)
        IDLE: begin
          if (error_flag) begin
            // Locked out until software acknowledges the error.
            if (err_clr) begin
              error_flag <= 1'b0;
            end
          end else if (start_flag) begin
            r_cmd_idx      <= cmd_index;
            r_data_present <= data_present;
            r_multiple_blk <= multiple_blk;
            blocks_left    <= multiple_blk ? block_count : 16'd1;
            if (w_bad_count) begin
              error_flag  <= 1'b1;
              cmd_inhibit <= 1'b0;
              dat_inhibit <= 1'b0;
              r_state     <= ERROR;
            end else begin
              cmd_inhibit   <= 1'b1;
              dat_inhibit   <= data_present;
              new_cmd       <= 1'b1;
              cmd_index_out <= cmd_index;
              r_state       <= ISSUE;
            end
          end
        end

        ISSUE: begin
          r_state <= WAIT_RESP;
        end

        WAIT_RESP: begin
          if (cmd_timeout) begin
            error_flag  <= 1'b1;
            cmd_inhibit <= 1'b0;
            dat_inhibit <= 1'b0;
            r_state     <= ERROR;
          end else if (cmd_complete) begin
            if (r_data_present) begin
              dat_start   <= 1'b1;
              cmd_inhibit <= 1'b0;
              r_wdog      <= '0;
              r_state     <= DATA;
            end else begin
              xfer_complete <= 1'b1;
              cmd_inhibit   <= 1'b0;
              dat_inhibit   <= 1'b0;
              r_state       <= DONE;
            end
          end
        end

        DATA: begin
          if (STOP) begin
            new_cmd       <= 1'b1;
            cmd_index_out <= STOP_CMD_IDX;
            cmd_inhibit   <= 1'b1;
            r_state       <= STOP_ISSUE;
          end else if (block_done) begin
            r_wdog <= '0;
            if (blocks_left != 16'd0) begin
              blocks_left <= blocks_left - 16'd1;
            end
            if (blocks_left == 16'd1) begin
              if (r_multiple_blk) begin
                new_cmd       <= 1'b1;
                cmd_index_out <= STOP_CMD_IDX;
                cmd_inhibit   <= 1'b1;
                r_state       <= STOP_ISSUE;
              end else begin
                xfer_complete <= 1'b1;
                cmd_inhibit   <= 1'b0;
                dat_inhibit   <= 1'b0;
                r_state       <= DONE;
              end
            end
          end else if (r_wdog == WD_LAST) begin
            error_flag  <= 1'b1;
            cmd_inhibit <= 1'b0;
            dat_inhibit <= 1'b0;
            r_state     <= ERROR;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end

        STOP_ISSUE: begin
          r_state <= STOP_WAIT;
        end

        STOP_WAIT: begin
          if (cmd_timeout) begin
            error_flag  <= 1'b1;
            cmd_inhibit <= 1'b0;
            dat_inhibit <= 1'b0;
            r_state     <= ERROR;
          end else if (cmd_complete) begin
            xfer_complete <= 1'b1;
            cmd_inhibit   <= 1'b0;
            dat_inhibit   <= 1'b0;
            r_state       <= DONE;
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        ERROR: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/xfer_sequencer.md
XFER_SEQUENCER -- requirements
Module: xfer_sequencer

Interface
REQ-001 SHALL have parameter DAT_TIMEOUT, default 4096: max CLK cycles between data-phase start/block_done events before error.
REQ-002 SHALL have port CLK input 1: host clock; all state changes on rising edge.
REQ-003 SHALL have port RESET input 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start_flag input 1: one-cycle pulse, new command requested.
REQ-005 SHALL have port cmd_index input 6: command index from command register.
REQ-006 SHALL have port data_present input 1: command has a data phase.
REQ-007 SHALL have port multiple_blk input 1: multi-block transfer, auto-CMD12 at end.
REQ-008 SHALL have port block_count input 16: blocks for multi-block transfer.
REQ-009 SHALL have port cmd_complete input 1: pulse, response received.
REQ-010 SHALL have port cmd_timeout input 1: pulse, response timeout.
REQ-011 SHALL have port block_done input 1: pulse, one data block finished.
REQ-012 SHALL have port STOP input 1: level, core abort of data phase.
REQ-013 SHALL have port err_clr input 1: pulse, clears error_flag.
REQ-014 SHALL have port new_cmd output 1: pulse to CMD block.
REQ-015 SHALL have port cmd_index_out output 6: index driven to CMD block.
REQ-016 SHALL have port dat_start output 1: pulse starting DAT and DMA.
REQ-017 SHALL have port cmd_inhibit output 1: PSR[0] value.
REQ-018 SHALL have port dat_inhibit output 1: PSR[1] value.
REQ-019 SHALL have port xfer_complete output 1: pulse, NISR[1] value.
REQ-020 SHALL have port error_flag output 1: sticky error.
REQ-021 SHALL have port blocks_left output 16: remaining blocks.

Function
REQ-022 SHALL implement states IDLE, ISSUE, WAIT_RESP, DATA, STOP_ISSUE, STOP_WAIT, DONE, ERROR.
REQ-023 IDLE: start_flag with error_flag=0 -> ISSUE; latch cmd_index, data_present, multiple_blk; blocks_left <= multiple_blk ? block_count : 1; cmd_inhibit <= 1; dat_inhibit <= data_present.
REQ-024 start_flag SHALL be ignored in every state except IDLE and in IDLE while error_flag=1.
REQ-025 Data phase with multiple_blk=1 and block_count=0 SHALL go IDLE -> ERROR directly, no new_cmd.
REQ-026 ISSUE: new_cmd=1 for exactly this one cycle, cmd_index_out=latched index -> WAIT_RESP.
REQ-027 WAIT_RESP: cmd_timeout -> ERROR (wins if simultaneous with cmd_complete); cmd_complete -> DATA with dat_start pulse same cycle and cmd_inhibit <= 0 if data phase, else DONE.
REQ-028 DATA: block_done decrements blocks_left (no wrap below 0); block_done with blocks_left=1 -> STOP_ISSUE if multiple_blk else DONE.
REQ-029 DATA: watchdog counter SHALL clear on entry and each block_done; reaching DAT_TIMEOUT -> ERROR.
REQ-030 DATA: STOP=1 -> STOP_ISSUE regardless of multiple_blk; STOP has priority over simultaneous block_done (no decrement).
REQ-031 STOP_ISSUE: new_cmd pulse, cmd_index_out=12, cmd_inhibit <= 1 -> STOP_WAIT.
REQ-032 STOP_WAIT: cmd_timeout -> ERROR; cmd_complete -> DONE.
REQ-033 DONE: xfer_complete=1 one cycle, cmd_inhibit <= 0, dat_inhibit <= 0 -> IDLE.
REQ-034 ERROR: error_flag <= 1, inhibits <= 0, no xfer_complete -> IDLE next cycle.
REQ-035 error_flag SHALL clear only on err_clr in IDLE; err_clr elsewhere ignored.
REQ-036 cmd_index_out SHALL hold last driven value outside ISSUE/STOP_ISSUE.
REQ-037 All outputs SHALL be registered; new_cmd, dat_start, xfer_complete never high >1 consecutive cycle.

Reset
REQ-038 RESET=1 SHALL asynchronously force IDLE; all outputs, blocks_left, watchdog, latched config to 0, including mid-transfer.

Verification
REQ-039 Single cmd, data_present=0: start_flag, cmd_complete 5 cycles later -> one new_cmd, xfer_complete pulse, cmd_inhibit 1->0, dat_inhibit stays 0.
REQ-040 Multi-block read, block_count=3: three block_done -> blocks_left 3,2,1,0; new_cmd with cmd_index_out=12; cmd_complete -> xfer_complete.
REQ-041 cmd_complete and cmd_timeout same cycle in WAIT_RESP -> ERROR, error_flag=1, no dat_start; later start_flag ignored until err_clr.
REQ-042 DATA with no block_done for DAT_TIMEOUT cycles (param 16) -> error_flag=1, dat_inhibit=0.
REQ-043 STOP asserted in DATA with blocks_left=2 and block_done same cycle -> blocks_left stays 2, CMD12 issued.
REQ-044 RESET asserted in DATA mid-transfer -> all outputs 0 immediately, state IDLE.
